custom_axi_regif: RTL and testbench
===================================

CUSTOM_AXI_REGIF -- requirements
Module: custom_axi_regif

Interface
REQ-001 Parameter: ADDR_W, 5, AXI4-Lite byte-address width.
REQ-002 Parameter: DATA_WIDTH, 96, width of reg2ip_data_o; fixed at 3 x 32 bits.
REQ-003 clk_i  in  1  clock, all logic rising-edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 awaddr_i  in  ADDR_W  write address; awvalid_i in 1; awready_o out 1.
REQ-006 wdata_i  in  32  write data; wstrb_i in 4 byte strobes; wvalid_i in 1; wready_o out 1.
REQ-007 bresp_o  out  2  write response; bvalid_o out 1; bready_i in 1.
REQ-008 araddr_i  in  ADDR_W  read address; arvalid_i in 1; arready_o out 1.
REQ-009 rdata_o  out  32  read data; rresp_o out 2; rvalid_o out 1; rready_i in 1.
REQ-010 reg2ip_data_o  out  96  shadow regs {CFG0,CFG1,CFG2}; CFG0 in [95:64].
REQ-011 reg2ip_en_o  out  3  one-cycle update pulse per shadow reg; bit0=CFG0, bit1=CFG1, bit2=CFG2.
REQ-012 ip2reg_data_i  in  99  IP result {R0,pad,R1,pad,R2,pad}: R0=[98:67], R1=[65:34], R2=[32:1].
REQ-013 ip2reg_en_i  in  3  per-result capture strobe; bit0=R0, bit1=R1, bit2=R2.

Function
REQ-014 Map: 0x00 CFG0 RW, 0x04 CFG1 RW, 0x08 CFG2 RW, 0x0C R0 RO, 0x10 R1 RO, 0x14 R2 RO, 0x18 STATUS (bits[2:0] sticky capture flags, W1C); upper STATUS bits read 0.
REQ-015 Write FSM states W_IDLE, W_RESP; AW and W handshakes accepted independently, each latched; awready_o=1 in W_IDLE with no AW latched, wready_o=1 in W_IDLE with no W latched.
REQ-016 At the edge where the second of AW/W completes (or both same cycle): register update applied, FSM -> W_RESP, bvalid_o=1 from next cycle until bvalid_o&&bready_i, then W_IDLE.
REQ-017 CFG writes honour wstrb_i per byte; reg2ip_en_o[i] high exactly one cycle, the same cycle bvalid_o first rises, even when wstrb_i=0.
REQ-018 Write to 0x0C-0x14 or unmapped address: no state change, no pulse, bresp_o=2'b10 (SLVERR); mapped RW/W1C write: bresp_o=2'b00.
REQ-019 Read FSM states R_IDLE, R_DATA; arready_o=1 only in R_IDLE; on accept, rdata_o/rresp_o registered, rvalid_o=1 next cycle, held stable until rvalid_o&&rready_i.
REQ-020 Read of unmapped address: rdata_o=0, rresp_o=2'b10; reads have no side effects.
REQ-021 ip2reg_en_i[k]=1: Rk captured from ip2reg_data_i at that edge, STATUS[k] set.
REQ-022 Simultaneous capture and W1C of same STATUS bit: set wins.
REQ-023 Simultaneous capture and read of same Rk: read returns value before that edge.
REQ-024 Read and write channels operate concurrently and independently; a read of CFGi in the cycle its write lands returns the old value.

Reset
REQ-025 rst_ni low: CFG0-2=0, R0-R2=0, STATUS=0, reg2ip_en_o=0, bvalid_o=0, rvalid_o=0, bresp_o=0, rresp_o=0, rdata_o=0, AW/W latches cleared, FSMs to W_IDLE/R_IDLE.
REQ-026 Reset mid-transaction discards pending AW/W/AR; no pulse or response issued afterwards for it.

Structure
REQ-027 Package custom_axi_pkg holds address offsets, RESP_OKAY/RESP_SLVERR, write/read FSM state enums, ip2reg field bit positions.
REQ-028 Single flat module, no sub-module.

Verification
REQ-029 AW+W same cycle, 0x04, data 0xA5A5_0001, strb 0xF -> reg2ip_data_o[63:32]=0xA5A50001, reg2ip_en_o=3'b010 one cycle, bresp_o=OKAY.
REQ-030 W two cycles before AW, 0x00, data 0x1234_5678, strb 0x3 -> CFG0=0x00005678, one pulse on bit0, bready_i held low 3 cycles keeps bvalid_o high.
REQ-031 ip2reg_en_i=3'b111 with R0=0x2468,R1=0x369C,R2=0x48D0 -> reads of 0x0C/0x10/0x14 return them, 0x18 returns 0x7.
REQ-032 W1C 0x18 data 0x7 in same cycle ip2reg_en_i=3'b001 -> STATUS reads 0x1.
REQ-033 Write 0x10 and read 0x1C -> both SLVERR, rdata_o=0, R1 unchanged, no reg2ip_en_o pulse.
REQ-034 rst_ni asserted after AW accepted, before W -> after release W alone causes no write, bvalid_o stays 0.

Source files
------------

// File: rtl/custom_axi_pkg.sv
// +----------------------------------------------------------------------+
// | custom_axi_pkg: register map, response codes, FSM states, IP fields   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package custom_axi_pkg;

  localparam int unsigned NUM_CFG  = 3;
  localparam int unsigned NUM_RES  = 3;
  localparam int unsigned REG_W    = 32;

  localparam logic [7:0] ADDR_CFG0   = 8'h00;
  localparam logic [7:0] ADDR_CFG1   = 8'h04;
  localparam logic [7:0] ADDR_CFG2   = 8'h08;
  localparam logic [7:0] ADDR_R0     = 8'h0C;
  localparam logic [7:0] ADDR_R1     = 8'h10;
  localparam logic [7:0] ADDR_R2     = 8'h14;
  localparam logic [7:0] ADDR_STATUS = 8'h18;

  localparam logic [2:0] IDX_CFG0   = 3'd0;
  localparam logic [2:0] IDX_CFG1   = 3'd1;
  localparam logic [2:0] IDX_CFG2   = 3'd2;
  localparam logic [2:0] IDX_R0     = 3'd3;
  localparam logic [2:0] IDX_R1     = 3'd4;
  localparam logic [2:0] IDX_R2     = 3'd5;
  localparam logic [2:0] IDX_STATUS = 3'd6;
  localparam logic [2:0] IDX_NONE   = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Result field LSB positions inside ip2reg_data_i (one pad bit below each)
  localparam int unsigned IP_R0_LSB = 67;
  localparam int unsigned IP_R1_LSB = 34;
  localparam int unsigned IP_R2_LSB = 1;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/custom_axi_regif.sv
// +----------------------------------------------------------------------+
// | custom_axi_regif: AXI4-Lite slave with 3 RW config regs, 3 captured   |
// | IP result regs and a W1C sticky status register.  Revision: 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module custom_axi_regif
  import custom_axi_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_WIDTH = 96
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_W-1:0]     awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  input  logic [ADDR_W-1:0]     araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [31:0]           rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] reg2ip_data_o,
  output logic [2:0]            reg2ip_en_o,
  input  logic [98:0]           ip2reg_data_i,
  input  logic [2:0]            ip2reg_en_i
);

  function automatic logic [2:0] decode(input logic [ADDR_W-1:0] addr);
    logic [2:0] idx;
    idx = IDX_NONE;
    if      (addr == ADDR_W'(ADDR_CFG0))   idx = IDX_CFG0;
    else if (addr == ADDR_W'(ADDR_CFG1))   idx = IDX_CFG1;
    else if (addr == ADDR_W'(ADDR_CFG2))   idx = IDX_CFG2;
    else if (addr == ADDR_W'(ADDR_R0))     idx = IDX_R0;
    else if (addr == ADDR_W'(ADDR_R1))     idx = IDX_R1;
    else if (addr == ADDR_W'(ADDR_R2))     idx = IDX_R2;
    else if (addr == ADDR_W'(ADDR_STATUS)) idx = IDX_STATUS;
    return idx;
  endfunction

  function automatic logic [REG_W-1:0] apply_strb(input logic [REG_W-1:0] old_v,
                                                  input logic [REG_W-1:0] new_v,
                                                  input logic [3:0]       strb);
    logic [REG_W-1:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  wr_state_e                    w_state_q, w_state_d;
  rd_state_e                    r_state_q, r_state_d;
  logic                         aw_vld_q, aw_vld_d;
  logic [ADDR_W-1:0]            aw_addr_q, aw_addr_d;
  logic                         w_vld_q, w_vld_d;
  logic [31:0]                  w_data_q, w_data_d;
  logic [3:0]                   w_strb_q, w_strb_d;
  logic [1:0]                   bresp_q, bresp_d;
  logic [2:0]                   en_q, en_d;
  logic [NUM_CFG-1:0][REG_W-1:0] cfg_q, cfg_d;
  logic [NUM_RES-1:0][REG_W-1:0] res_q, res_d;
  logic [NUM_RES-1:0]           status_q, status_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic [1:0]                   rresp_q, rresp_d;

  logic              aw_fire, w_fire, aw_have, w_have, wr_commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [2:0]        wr_idx, rd_idx;
  logic              unused_ip_pad;

  assign awready_o = (w_state_q == W_IDLE) && !aw_vld_q;
  assign wready_o  = (w_state_q == W_IDLE) && !w_vld_q;
  assign aw_fire   = awvalid_i && awready_o;
  assign w_fire    = wvalid_i && wready_o;
  assign aw_have   = aw_vld_q || aw_fire;
  assign w_have    = w_vld_q || w_fire;
  assign wr_commit = (w_state_q == W_IDLE) && aw_have && w_have;

  // A freshly handshaken beat is used directly when its partner is already held
  assign wr_addr = aw_vld_q ? aw_addr_q : awaddr_i;
  assign wr_data = w_vld_q ? w_data_q : wdata_i;
  assign wr_strb = w_vld_q ? w_strb_q : wstrb_i;
  assign wr_idx  = decode(wr_addr);
  assign rd_idx  = decode(araddr_i);

  assign unused_ip_pad = ^{ip2reg_data_i[66], ip2reg_data_i[33], ip2reg_data_i[0]};

  always_comb begin
    w_state_d = w_state_q;
    aw_vld_d  = aw_vld_q;
    aw_addr_d = aw_addr_q;
    w_vld_d   = w_vld_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    en_d      = '0;
    unique case (w_state_q)
      W_IDLE: begin
        if (wr_commit) begin
          aw_vld_d  = 1'b0;
          w_vld_d   = 1'b0;
          w_state_d = W_RESP;
          if (wr_idx <= IDX_CFG2) begin
            bresp_d            = RESP_OKAY;
            en_d[wr_idx[1:0]]  = 1'b1;
          end else if (wr_idx == IDX_STATUS) begin
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end else begin
          if (aw_fire) begin
            aw_vld_d  = 1'b1;
            aw_addr_d = awaddr_i;
          end
          if (w_fire) begin
            w_vld_d  = 1'b1;
            w_data_d = wdata_i;
            w_strb_d = wstrb_i;
          end
        end
      end
      W_RESP: begin
        if (bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    cfg_d    = cfg_q;
    res_d    = res_q;
    status_d = status_q;
    if (wr_commit) begin
      if (wr_idx == IDX_CFG0) cfg_d[0] = apply_strb(cfg_q[0], wr_data, wr_strb);
      if (wr_idx == IDX_CFG1) cfg_d[1] = apply_strb(cfg_q[1], wr_data, wr_strb);
      if (wr_idx == IDX_CFG2) cfg_d[2] = apply_strb(cfg_q[2], wr_data, wr_strb);
      // Flags live in byte 0, so only that strobe enables the clear
      if (wr_idx == IDX_STATUS && wr_strb[0]) status_d = status_q & ~wr_data[NUM_RES-1:0];
    end
    if (ip2reg_en_i[0]) res_d[0] = ip2reg_data_i[IP_R0_LSB +: REG_W];
    if (ip2reg_en_i[1]) res_d[1] = ip2reg_data_i[IP_R1_LSB +: REG_W];
    if (ip2reg_en_i[2]) res_d[2] = ip2reg_data_i[IP_R2_LSB +: REG_W];
    status_d = status_d | ip2reg_en_i;
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid_i) begin
          r_state_d = R_DATA;
          rresp_d   = RESP_OKAY;
          unique case (rd_idx)
            IDX_CFG0:   rdata_d = cfg_q[0];
            IDX_CFG1:   rdata_d = cfg_q[1];
            IDX_CFG2:   rdata_d = cfg_q[2];
            IDX_R0:     rdata_d = res_q[0];
            IDX_R1:     rdata_d = res_q[1];
            IDX_R2:     rdata_d = res_q[2];
            IDX_STATUS: rdata_d = {{(32-NUM_RES){1'b0}}, status_q};
            default: begin
              rdata_d = '0;
              rresp_d = RESP_SLVERR;
            end
          endcase
        end
      end
      R_DATA: begin
        if (rready_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_vld_q  <= 1'b0;
      aw_addr_q <= '0;
      w_vld_q   <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= '0;
      en_q      <= '0;
      cfg_q     <= '0;
      res_q     <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_vld_q  <= aw_vld_d;
      aw_addr_q <= aw_addr_d;
      w_vld_q   <= w_vld_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
      en_q      <= en_d;
      cfg_q     <= cfg_d;
      res_q     <= res_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bvalid_o      = (w_state_q == W_RESP);
  assign bresp_o       = bresp_q;
  assign arready_o     = (r_state_q == R_IDLE);
  assign rvalid_o      = (r_state_q == R_DATA);
  assign rdata_o       = rdata_q;
  assign rresp_o       = rresp_q;
  assign reg2ip_en_o   = en_q;
  assign reg2ip_data_o = {cfg_q[0], cfg_q[1], cfg_q[2]};

endmodule

`default_nettype wire

// File: tb/tb_custom_axi_regif.sv
// +----------------------------------------------------------------------+
// | tb_custom_axi_regif: directed stimulus checked against a register-map |
// | model of custom_axi_regif.  Revision: 1.0                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_custom_axi_regif;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [4:0]  awaddr_i = '0;
  logic        awvalid_i = 1'b0;
  logic        awready_o;
  logic [31:0] wdata_i = '0;
  logic [3:0]  wstrb_i = '0;
  logic        wvalid_i = 1'b0;
  logic        wready_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i = 1'b0;
  logic [4:0]  araddr_i = '0;
  logic        arvalid_i = 1'b0;
  logic        arready_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rvalid_o;
  logic        rready_i = 1'b0;
  logic [95:0] reg2ip_data_o;
  logic [2:0]  reg2ip_en_o;
  logic [98:0] ip2reg_data_i = '0;
  logic [2:0]  ip2reg_en_i = '0;

  always #5 clk_i = ~clk_i;

  custom_axi_regif #(.ADDR_W(5), .DATA_WIDTH(96)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .reg2ip_data_o(reg2ip_data_o), .reg2ip_en_o(reg2ip_en_o),
    .ip2reg_data_i(ip2reg_data_i), .ip2reg_en_i(ip2reg_en_i)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Register-map model: contents and what the outputs must currently show
  logic [31:0] m_cfg [3];
  logic [31:0] m_res [3];
  logic [2:0]  m_status = '0;
  logic [2:0]  m_en     = '0;
  logic [2:0]  last_cap = '0;
  bit          m_bvalid = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cfg[i] = '0;
      m_res[i] = '0;
    end
    m_status = '0;
    m_en     = '0;
    m_bvalid = 1'b0;
  endfunction

  function automatic void model_read(input logic [4:0] a, output logic [31:0] d,
                                     output logic [1:0] r);
    r = 2'b00;
    case (a)
      5'h00:   d = m_cfg[0];
      5'h04:   d = m_cfg[1];
      5'h08:   d = m_cfg[2];
      5'h0C:   d = m_res[0];
      5'h10:   d = m_res[1];
      5'h14:   d = m_res[2];
      5'h18:   d = {29'd0, m_status};
      default: begin d = '0; r = 2'b10; end
    endcase
  endfunction

  function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int i;
    i = -1;
    if (a == 5'h00) i = 0;
    if (a == 5'h04) i = 1;
    if (a == 5'h08) i = 2;
    if (i >= 0) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_cfg[i][8*b +: 8] = d[8*b +: 8];
      m_en[i] = 1'b1;
      return 2'b00;
    end
    if (a == 5'h18) begin
      // A capture landing on the same edge re-sets its flag
      m_status = (m_status & ~(s[0] ? d[2:0] : 3'b000)) | last_cap;
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic logic [98:0] pack_ip(input logic [31:0] r0, input logic [31:0] r1,
                                          input logic [31:0] r2);
    return {r0, 1'b0, r1, 1'b0, r2, 1'b0};
  endfunction

  // One clock edge; the model absorbs any capture presented to it
  task automatic tick();
    logic [2:0]  cap;
    logic [98:0] dat;
    cap = ip2reg_en_i;
    dat = ip2reg_data_i;
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (cap[k]) begin
        m_res[k]    = dat[67 - 33*k +: 32];
        m_status[k] = 1'b1;
      end
    end
    last_cap    = cap;
    ip2reg_en_i = '0;
  endtask

  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("reg2ip_data", reg2ip_data_o, {m_cfg[0], m_cfg[1], m_cfg[2]});
      chk("reg2ip_en", 96'(reg2ip_en_o), 96'(m_en));
      chk("bvalid", 96'(bvalid_o), 96'(m_bvalid));
    end
  end

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp);
    bit aw_done, w_done, aw_f, w_f, done;
    logic [1:0] exp_resp;
    aw_done = 0; w_done = 0; done = 0;
    awaddr_i = a; wdata_i = d; wstrb_i = s;
    for (int c = 0; c < 20 && !done; c++) begin
      awvalid_i = (c >= aw_dly) && !aw_done;
      wvalid_i  = (c >= w_dly) && !w_done;
      @(negedge clk_i);
      aw_f = awvalid_i && awready_o;
      w_f  = wvalid_i && wready_o;
      tick();
      aw_done = aw_done | aw_f;
      w_done  = w_done | w_f;
      done    = aw_done && w_done;
    end
    awvalid_i = 0;
    wvalid_i  = 0;
    resp = 2'bxx;
    if (!done) begin
      chk("write_handshake_timeout", 96'(0), 96'(1));
      return;
    end
    exp_resp = model_write(a, d, s);
    m_bvalid = 1'b1;
    for (int c = 0; c <= b_dly; c++) begin
      bready_i = (c == b_dly);
      @(negedge clk_i);
      chk("bresp", 96'(bresp_o), 96'(exp_resp));
      resp = bresp_o;
      tick();
      m_en = '0;
    end
    bready_i = 0;
    m_bvalid = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input int r_dly,
                         output logic [31:0] d, output logic [1:0] r);
    bit fire;
    logic [31:0] ed;
    logic [1:0]  er;
    fire = 0; ed = '0; er = '0;
    arvalid_i = 1; araddr_i = a;
    for (int c = 0; c < 20 && !fire; c++) begin
      @(negedge clk_i);
      fire = arready_o;
      if (fire) model_read(a, ed, er);
      tick();
    end
    arvalid_i = 0;
    d = 'x; r = 'x;
    if (!fire) begin
      chk("read_accept_timeout", 96'(0), 96'(1));
      return;
    end
    for (int c = 0; c <= r_dly; c++) begin
      rready_i = (c == r_dly);
      @(negedge clk_i);
      chk("rvalid", 96'(rvalid_o), 96'(1));
      chk("rdata", 96'(rdata_o), 96'(ed));
      chk("rresp", 96'(rresp_o), 96'(er));
      d = rdata_o;
      r = rresp_o;
      tick();
    end
    rready_i = 0;
    chk("rvalid_drop", 96'(rvalid_o), 96'(0));
  endtask

  logic [1:0]  resp, rresp;
  logic [31:0] rd;

  initial begin
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_bvalid", 96'(bvalid_o), 96'(0));
    chk("rst_rvalid", 96'(rvalid_o), 96'(0));
    chk("rst_outputs", {reg2ip_data_o}, 96'(0));
    chk("rst_misc", 96'({reg2ip_en_o, bresp_o, rresp_o, rdata_o}), 96'(0));
    rst_ni = 1;
    chk("rst_readies", 96'({awready_o, wready_o, arready_o}), 96'(3'b111));
    cmp_en = 1;

    do_write(5'h04, 32'hA5A5_0001, 4'hF, 0, 0, 0, resp);
    chk("cfg1_value", 96'(reg2ip_data_o[63:32]), 96'(32'hA5A5_0001));
    chk("cfg1_bresp", 96'(resp), 96'(2'b00));

    do_write(5'h00, 32'h1234_5678, 4'h3, 2, 0, 3, resp);
    chk("cfg0_strb", 96'(reg2ip_data_o[95:64]), 96'(32'h0000_5678));

    do_write(5'h08, 32'hDEAD_BEEF, 4'b1010, 0, 1, 0, resp);
    chk("cfg2_strb", 96'(reg2ip_data_o[31:0]), 96'(32'hDE00_BE00));
    do_write(5'h08, 32'hFFFF_FFFF, 4'b0000, 0, 0, 1, resp);
    chk("cfg2_nostrb", 96'(reg2ip_data_o[31:0]), 96'(32'hDE00_BE00));

    do_read(5'h00, 2, rd, rresp);
    chk("rd_cfg0", 96'(rd), 96'(32'h0000_5678));

    ip2reg_data_i = pack_ip(32'h2468, 32'h369C, 32'h48D0);
    ip2reg_en_i   = 3'b111;
    tick();
    do_read(5'h0C, 0, rd, rresp); chk("rd_r0", 96'(rd), 96'(32'h2468));
    do_read(5'h10, 0, rd, rresp); chk("rd_r1", 96'(rd), 96'(32'h369C));
    do_read(5'h14, 1, rd, rresp); chk("rd_r2", 96'(rd), 96'(32'h48D0));
    do_read(5'h18, 0, rd, rresp); chk("rd_status7", 96'(rd), 96'(32'h7));

    ip2reg_data_i = pack_ip(32'h1111, 32'h369C, 32'h48D0);
    ip2reg_en_i   = 3'b001;
    do_write(5'h18, 32'h7, 4'hF, 0, 0, 0, resp);
    do_read(5'h18, 0, rd, rresp); chk("w1c_set_wins", 96'(rd), 96'(32'h1));
    do_read(5'h0C, 0, rd, rresp); chk("rd_r0_new", 96'(rd), 96'(32'h1111));

    ip2reg_data_i = pack_ip(32'h1111, 32'hBEEF, 32'h48D0);
    ip2reg_en_i   = 3'b010;
    do_read(5'h10, 0, rd, rresp); chk("rd_r1_old", 96'(rd), 96'(32'h369C));
    do_read(5'h10, 0, rd, rresp); chk("rd_r1_new", 96'(rd), 96'(32'hBEEF));
    do_read(5'h18, 0, rd, rresp); chk("rd_status3", 96'(rd), 96'(32'h3));

    fork
      do_write(5'h04, 32'hCAFE_F00D, 4'hF, 0, 0, 0, resp);
      do_read(5'h04, 0, rd, rresp);
    join
    chk("rd_cfg1_old", 96'(rd), 96'(32'hA5A5_0001));
    chk("cfg1_new", 96'(reg2ip_data_o[63:32]), 96'(32'hCAFE_F00D));

    do_write(5'h10, 32'h5555_5555, 4'hF, 0, 0, 0, resp);
    chk("ro_bresp", 96'(resp), 96'(2'b10));
    do_read(5'h1C, 0, rd, rresp);
    chk("unmapped_rdata", 96'(rd), 96'(0));
    chk("unmapped_rresp", 96'(rresp), 96'(2'b10));
    do_read(5'h10, 0, rd, rresp); chk("r1_kept", 96'(rd), 96'(32'hBEEF));

    awaddr_i  = 5'h08;
    awvalid_i = 1;
    @(negedge clk_i);
    chk("aw_before_reset", 96'(awready_o), 96'(1));
    tick();
    awvalid_i = 0;
    cmp_en = 0;
    rst_ni = 0;
    model_reset();
    tick();
    tick();
    rst_ni = 1;
    cmp_en = 1;
    wdata_i  = 32'hFFFF_FFFF;
    wstrb_i  = 4'hF;
    wvalid_i = 1;
    @(negedge clk_i);
    chk("w_after_reset", 96'(wready_o), 96'(1));
    tick();
    wvalid_i = 0;
    repeat (4) tick();
    chk("aw_discarded", 96'(awready_o), 96'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
